// File: rtl/axi4_sram_bridge.sv
// AXI4 slave that turns each read or write burst into a series of single-beat
// requests on a request/ready, response-valid memory port. At most one request is outstanding.
module axi4_sram_bridge #(
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BYTES = 8,
    parameter int ID_BITS    = 5,
    parameter int USER_BITS  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic                    i_aw_valid,
    output logic                    o_aw_ready,
    input  logic [ADDR_BITS-1:0]    i_aw_addr,
    input  logic [7:0]              i_aw_len,
    input  logic [2:0]              i_aw_size,
    input  logic [1:0]              i_aw_burst,
    input  logic [ID_BITS-1:0]      i_aw_id,
    input  logic [USER_BITS-1:0]    i_aw_user,
    input  logic                    i_w_valid,
    output logic                    o_w_ready,
    input  logic [8*DATA_BYTES-1:0] i_w_data,
    input  logic [DATA_BYTES-1:0]   i_w_strb,
    input  logic                    i_w_last,
    output logic                    o_b_valid,
    input  logic                    i_b_ready,
    output logic [1:0]              o_b_resp,
    output logic [ID_BITS-1:0]      o_b_id,
    output logic [USER_BITS-1:0]    o_b_user,
    input  logic                    i_ar_valid,
    output logic                    o_ar_ready,
    input  logic [ADDR_BITS-1:0]    i_ar_addr,
    input  logic [7:0]              i_ar_len,
    input  logic [2:0]              i_ar_size,
    input  logic [1:0]              i_ar_burst,
    input  logic [ID_BITS-1:0]      i_ar_id,
    input  logic [USER_BITS-1:0]    i_ar_user,
    output logic                    o_r_valid,
    input  logic                    i_r_ready,
    output logic [8*DATA_BYTES-1:0] o_r_data,
    output logic [1:0]              o_r_resp,
    output logic                    o_r_last,
    output logic [ID_BITS-1:0]      o_r_id,
    output logic [USER_BITS-1:0]    o_r_user,
    output logic                    o_req_valid,
    output logic                    o_req_write,
    output logic [ADDR_BITS-1:0]    o_req_addr,
    output logic [8*DATA_BYTES-1:0] o_req_wdata,
    output logic [DATA_BYTES-1:0]   o_req_wstrb,
    input  logic                    i_req_ready,
    input  logic                    i_resp_valid,
    input  logic [8*DATA_BYTES-1:0] i_resp_rdata,
    input  logic                    i_resp_err
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [2:0] SIZE_MAX    = 3'($clog2(DATA_BYTES));

    typedef enum logic [2:0] {
        IDLE, R_REQ, R_WAIT, R_DATA, W_DATA, W_REQ, W_WAIT, B_RESP
    } state_t;

    state_t                  state;
    logic                    prio_read;
    logic [ADDR_BITS-1:0]    addr;
    logic [7:0]              len;
    logic [7:0]              cnt;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [ID_BITS-1:0]      id;
    logic [USER_BITS-1:0]    user;
    logic                    bad;
    logic                    err;
    logic [8*DATA_BYTES-1:0] r_data;
    logic [1:0]              r_resp;
    logic [8*DATA_BYTES-1:0] wdata;
    logic [DATA_BYTES-1:0]   wstrb;

    logic                    sel_read;
    logic                    sel_write;
    logic                    bad_ar;
    logic                    bad_aw;
    logic [ADDR_BITS-1:0]    step;
    logic [ADDR_BITS-1:0]    incr;
    logic [ADDR_BITS-1:0]    wrap_mask;
    logic [ADDR_BITS-1:0]    adv_addr;
    logic                    unused_w_last;

    // The beat counter alone decides when a write burst ends; WLAST is not consulted.
    assign unused_w_last = i_w_last;

    assign sel_read  = i_ar_valid && (!i_aw_valid || prio_read);
    assign sel_write = i_aw_valid && (!i_ar_valid || !prio_read);
    assign bad_ar    = (i_ar_burst == BURST_RSVD) || (i_ar_size > SIZE_MAX);
    assign bad_aw    = (i_aw_burst == BURST_RSVD) || (i_aw_size > SIZE_MAX);

    // WRAP keeps the address inside a (len+1)*step window aligned to its own size.
    always_comb begin
        step      = ADDR_BITS'(1) << size;
        incr      = addr + step;
        wrap_mask = ((ADDR_BITS'(len) + ADDR_BITS'(1)) << size) - ADDR_BITS'(1);
        case (burst)
            BURST_FIXED: adv_addr = addr;
            BURST_WRAP:  adv_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     adv_addr = incr;
        endcase
    end

    assign o_ar_ready  = i_nrst && (state == IDLE) && sel_read;
    assign o_aw_ready  = i_nrst && (state == IDLE) && sel_write;
    assign o_w_ready   = (state == W_DATA);
    assign o_req_valid = (state == R_REQ) || (state == W_REQ);
    assign o_req_write = (state == W_REQ);
    assign o_req_addr  = addr;
    assign o_req_wdata = wdata;
    assign o_req_wstrb = wstrb;
    assign o_r_valid   = (state == R_DATA);
    assign o_r_data    = r_data;
    assign o_r_resp    = r_resp;
    assign o_r_last    = (state == R_DATA) && (cnt == 8'd0);
    assign o_r_id      = id;
    assign o_r_user    = user;
    assign o_b_valid   = (state == B_RESP);
    assign o_b_resp    = (state == B_RESP && err) ? RESP_SLVERR : RESP_OKAY;
    assign o_b_id      = id;
    assign o_b_user    = user;

    // NOTE: all state below updates with <= so every branch sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= IDLE;
            prio_read <= 1'b1;
            addr      <= '0;
            len       <= '0;
            cnt       <= '0;
            size      <= '0;
            burst     <= '0;
            id        <= '0;
            user      <= '0;
            bad       <= 1'b0;
            err       <= 1'b0;
            r_data    <= '0;
            r_resp    <= RESP_OKAY;
            wdata     <= '0;
            wstrb     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_read) begin
                        addr      <= i_ar_addr;
                        len       <= i_ar_len;
                        cnt       <= i_ar_len;
                        size      <= i_ar_size;
                        burst     <= i_ar_burst;
                        id        <= i_ar_id;
                        user      <= i_ar_user;
                        bad       <= bad_ar;
                        prio_read <= 1'b0;
                        if (bad_ar) begin
                            r_data <= '0;
                            r_resp <= RESP_SLVERR;
                            state  <= R_DATA;
                        end else begin
                            state  <= R_REQ;
                        end
                    end else if (sel_write) begin
                        addr      <= i_aw_addr;
                        len       <= i_aw_len;
                        cnt       <= i_aw_len;
                        size      <= i_aw_size;
                        burst     <= i_aw_burst;
                        id        <= i_aw_id;
                        user      <= i_aw_user;
                        bad       <= bad_aw;
                        err       <= bad_aw;
                        prio_read <= 1'b1;
                        state     <= W_DATA;
                    end
                end
                R_REQ: if (i_req_ready) state <= R_WAIT;
                R_WAIT: begin
                    if (i_resp_valid) begin
                        r_data <= i_resp_rdata;
                        r_resp <= i_resp_err ? RESP_SLVERR : RESP_OKAY;
                        state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (i_r_ready) begin
                        if (cnt == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            addr  <= adv_addr;
                            cnt   <= cnt - 8'd1;
                            state <= bad ? R_DATA : R_REQ;
                        end
                    end
                end
                W_DATA: begin
                    if (i_w_valid) begin
                        wdata <= i_w_data;
                        wstrb <= i_w_strb;
                        if (!bad) begin
                            state <= W_REQ;
                        end else if (cnt == 8'd0) begin
                            state <= B_RESP;
                        end else begin
                            addr <= adv_addr;
                            cnt  <= cnt - 8'd1;
                        end
                    end
                end
                W_REQ: if (i_req_ready) state <= W_WAIT;
                W_WAIT: begin
                    if (i_resp_valid) begin
                        err <= err | i_resp_err;
                        if (cnt == 8'd0) begin
                            state <= B_RESP;
                        end else begin
                            addr  <= adv_addr;
                            cnt   <= cnt - 8'd1;
                            state <= W_DATA;
                        end
                    end
                end
                B_RESP: begin
                    if (i_b_ready) begin
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_sram_bridge.sv
// Directed bench for axi4_sram_bridge: a one-cycle-latency memory model plus R/B monitors
// feed queues that are compared against hand-computed expectations.
module tb_axi4_sram_bridge;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [4:0]  id;
        logic        user;
    } rbeat_t;

    logic        i_clk, i_nrst;
    logic        i_aw_valid, o_aw_ready;
    logic [31:0] i_aw_addr;
    logic [7:0]  i_aw_len;
    logic [2:0]  i_aw_size;
    logic [1:0]  i_aw_burst;
    logic [4:0]  i_aw_id;
    logic        i_aw_user;
    logic        i_w_valid, o_w_ready;
    logic [63:0] i_w_data;
    logic [7:0]  i_w_strb;
    logic        i_w_last;
    logic        o_b_valid, i_b_ready;
    logic [1:0]  o_b_resp;
    logic [4:0]  o_b_id;
    logic        o_b_user;
    logic        i_ar_valid, o_ar_ready;
    logic [31:0] i_ar_addr;
    logic [7:0]  i_ar_len;
    logic [2:0]  i_ar_size;
    logic [1:0]  i_ar_burst;
    logic [4:0]  i_ar_id;
    logic        i_ar_user;
    logic        o_r_valid, i_r_ready;
    logic [63:0] o_r_data;
    logic [1:0]  o_r_resp;
    logic        o_r_last;
    logic [4:0]  o_r_id;
    logic        o_r_user;
    logic        o_req_valid, o_req_write;
    logic [31:0] o_req_addr;
    logic [63:0] o_req_wdata;
    logic [7:0]  o_req_wstrb;
    logic        i_req_ready, i_resp_valid, i_resp_err;
    logic [63:0] i_resp_rdata;

    int checks = 0;
    int errors = 0;

    req_t        req_log[$];
    rbeat_t      r_log[$];
    logic [6:0]  b_log[$];     // {user, id, resp}
    logic [64:0] rd_q[$];      // {err, data} per read request
    logic        wr_err_q[$];

    axi4_sram_bridge dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_aw_valid(i_aw_valid), .o_aw_ready(o_aw_ready), .i_aw_addr(i_aw_addr),
        .i_aw_len(i_aw_len), .i_aw_size(i_aw_size), .i_aw_burst(i_aw_burst),
        .i_aw_id(i_aw_id), .i_aw_user(i_aw_user),
        .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data),
        .i_w_strb(i_w_strb), .i_w_last(i_w_last),
        .o_b_valid(o_b_valid), .i_b_ready(i_b_ready), .o_b_resp(o_b_resp),
        .o_b_id(o_b_id), .o_b_user(o_b_user),
        .i_ar_valid(i_ar_valid), .o_ar_ready(o_ar_ready), .i_ar_addr(i_ar_addr),
        .i_ar_len(i_ar_len), .i_ar_size(i_ar_size), .i_ar_burst(i_ar_burst),
        .i_ar_id(i_ar_id), .i_ar_user(i_ar_user),
        .o_r_valid(o_r_valid), .i_r_ready(i_r_ready), .o_r_data(o_r_data),
        .o_r_resp(o_r_resp), .o_r_last(o_r_last), .o_r_id(o_r_id), .o_r_user(o_r_user),
        .o_req_valid(o_req_valid), .o_req_write(o_req_write), .o_req_addr(o_req_addr),
        .o_req_wdata(o_req_wdata), .o_req_wstrb(o_req_wstrb), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata), .i_resp_err(i_resp_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: answers one cycle after each accepted request.
    initial begin
        logic        pend;
        logic [63:0] pdata;
        logic        perr;
        pend = 1'b0; pdata = '0; perr = 1'b0;
        i_resp_valid = 1'b0; i_resp_rdata = '0; i_resp_err = 1'b0;
        forever begin
            @(negedge i_clk);
            i_resp_valid = pend; i_resp_rdata = pdata; i_resp_err = perr;
            pend = 1'b0;
            if (i_nrst && o_req_valid && i_req_ready) begin
                req_log.push_back('{o_req_write, o_req_addr, o_req_wdata, o_req_wstrb});
                pend = 1'b1;
                if (o_req_write) begin
                    pdata = '0;
                    perr  = (wr_err_q.size() > 0) ? wr_err_q.pop_front() : 1'b0;
                end else if (rd_q.size() > 0) begin
                    {perr, pdata} = rd_q.pop_front();
                end else begin
                    {perr, pdata} = 65'd0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (i_nrst && o_r_valid && i_r_ready)
                r_log.push_back('{o_r_data, o_r_resp, o_r_last, o_r_id, o_r_user});
            if (i_nrst && o_b_valid && i_b_ready)
                b_log.push_back({o_b_user, o_b_id, o_b_resp});
        end
    end

    // Handshake tasks start and return at posedge+1.
    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [4:0] id, input logic u);
        i_ar_addr = a; i_ar_len = l; i_ar_size = s; i_ar_burst = b; i_ar_id = id; i_ar_user = u;
        i_ar_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_ar_ready) break;
        end
        check("ar_handshake", o_ar_ready, 1);
        @(posedge i_clk); #1;
        i_ar_valid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [4:0] id, input logic u);
        i_aw_addr = a; i_aw_len = l; i_aw_size = s; i_aw_burst = b; i_aw_id = id; i_aw_user = u;
        i_aw_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_aw_ready) break;
        end
        check("aw_handshake", o_aw_ready, 1);
        @(posedge i_clk); #1;
        i_aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
        i_w_data = d; i_w_strb = strb; i_w_last = last; i_w_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_w_ready) break;
        end
        check("w_handshake", o_w_ready, 1);
        @(posedge i_clk); #1;
        i_w_valid = 1'b0;
    endtask

    task automatic wait_r(input int n);
        for (int i = 0; i < 200 && r_log.size() < n; i++) @(negedge i_clk);
        check("r_beat_count", r_log.size(), n);
        @(posedge i_clk); #1;
    endtask

    task automatic wait_b(input int n);
        for (int i = 0; i < 200 && b_log.size() < n; i++) @(negedge i_clk);
        check("b_count", b_log.size(), n);
        @(posedge i_clk); #1;
    endtask

    task automatic clear_logs();
        req_log.delete(); r_log.delete(); b_log.delete();
    endtask

    initial begin
        i_nrst = 1'b0;
        i_aw_valid = 0; i_aw_addr = 0; i_aw_len = 0; i_aw_size = 3; i_aw_burst = INCR;
        i_aw_id = 0; i_aw_user = 0;
        i_w_valid = 0; i_w_data = 0; i_w_strb = 0; i_w_last = 0;
        i_ar_valid = 0; i_ar_addr = 0; i_ar_len = 0; i_ar_size = 3; i_ar_burst = INCR;
        i_ar_id = 0; i_ar_user = 0;
        i_r_ready = 1; i_b_ready = 1; i_req_ready = 1;

        // Reset values
        repeat (3) @(negedge i_clk);
        check("rst_valids", {o_ar_ready, o_aw_ready, o_w_ready, o_b_valid, o_r_valid, o_req_valid}, 0);
        check("rst_req_addr", o_req_addr, 0);
        check("rst_r_data", o_r_data, 0);
        check("rst_b_resp", o_b_resp, 0);
        i_ar_valid = 1'b1; #1;
        check("rst_ar_ready_held", o_ar_ready, 0);
        i_ar_valid = 1'b0;
        @(negedge i_clk); i_nrst = 1'b1;
        @(posedge i_clk); #1;

        // Arbitration: collision goes to read, the next collision to write
        clear_logs();
        rd_q.push_back({1'b0, 64'hAA}); rd_q.push_back({1'b0, 64'hBB}); wr_err_q.push_back(1'b0);
        i_ar_addr = 32'h3000; i_ar_len = 0; i_ar_size = 3; i_ar_burst = INCR; i_ar_id = 1;
        i_aw_addr = 32'h4000; i_aw_len = 0; i_aw_size = 3; i_aw_burst = INCR; i_aw_id = 3;
        i_ar_valid = 1'b1; i_aw_valid = 1'b1;
        @(negedge i_clk);
        check("arb1_ready", {o_ar_ready, o_aw_ready}, 2'b10);
        @(posedge i_clk); #1;
        i_ar_addr = 32'h3100; i_ar_id = 2;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_ar_ready || o_aw_ready) break;
        end
        check("arb2_ready", {o_ar_ready, o_aw_ready}, 2'b01);
        @(posedge i_clk); #1;
        i_aw_valid = 1'b0;
        send_w(64'hCAFE, 8'hFF, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_ar_ready) break;
        end
        check("arb3_ar_ready", o_ar_ready, 1);
        @(posedge i_clk); #1;
        i_ar_valid = 1'b0;
        wait_r(2);
        wait_b(1);
        check("arb_req_count", req_log.size(), 3);
        check("arb_req0", {req_log[0].write, req_log[0].addr}, {1'b0, 32'h3000});
        check("arb_req1", {req_log[1].write, req_log[1].addr}, {1'b1, 32'h4000});
        check("arb_req2", {req_log[2].write, req_log[2].addr}, {1'b0, 32'h3100});
        check("arb_rdata", {r_log[0].data, r_log[1].data}, {64'hAA, 64'hBB});
        check("arb_b", b_log[0], {1'b0, 5'd3, 2'b00});

        // INCR read with an R stall on the first beat
        clear_logs();
        for (int i = 1; i <= 4; i++) rd_q.push_back({1'b0, 64'(8'h11 * i)});
        i_r_ready = 1'b0;
        send_ar(32'h1000, 8'd3, 3'd3, INCR, 5'd5, 1'b1);
        for (int i = 0; i < 50 && !o_r_valid; i++) @(negedge i_clk);
        repeat (2) @(negedge i_clk);
        check("incr_stall_hold", {o_r_valid, o_r_last, o_r_data}, {1'b1, 1'b0, 64'h11});
        @(posedge i_clk); #1;
        i_r_ready = 1'b1;
        wait_r(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_addr%0d", i), req_log[i].addr, 32'h1000 + 32'(8 * i));
            check($sformatf("incr_beat%0d", i), {r_log[i].data, r_log[i].resp, r_log[i].last},
                  {64'(8'h11 * (i + 1)), 2'b00, (i == 3)});
        end
        check("incr_id_user", {r_log[3].id, r_log[3].user}, {5'd5, 1'b1});

        // WRAP read
        clear_logs();
        for (int i = 0; i < 4; i++) rd_q.push_back({1'b0, 64'(i)});
        send_ar(32'h1018, 8'd3, 3'd3, WRAP, 5'd2, 1'b0);
        wait_r(4);
        check("wrap_addr0", req_log[0].addr, 32'h1018);
        check("wrap_addr1", req_log[1].addr, 32'h1000);
        check("wrap_addr2", req_log[2].addr, 32'h1008);
        check("wrap_addr3", req_log[3].addr, 32'h1010);

        // Write with error on the second beat
        clear_logs();
        wr_err_q.push_back(1'b0); wr_err_q.push_back(1'b1);
        send_aw(32'h2000, 8'd1, 3'd3, INCR, 5'd7, 1'b0);
        send_w(64'h1111_2222_3333_4444, 8'hF0, 1'b0);
        send_w(64'h5555_6666_7777_8888, 8'h0F, 1'b1);
        wait_b(1);
        check("wr_req_count", req_log.size(), 2);
        check("wr_req0", {req_log[0].write, req_log[0].addr, req_log[0].wstrb}, {1'b1, 32'h2000, 8'hF0});
        check("wr_req1", {req_log[1].write, req_log[1].addr, req_log[1].wstrb}, {1'b1, 32'h2008, 8'h0F});
        check("wr_wdata1", req_log[1].wdata, 64'h5555_6666_7777_8888);
        check("wr_b", b_log[0], {1'b0, 5'd7, 2'b10});

        // Reserved burst type: no memory traffic, SLVERR beats
        clear_logs();
        send_ar(32'h5000, 8'd1, 3'd3, RSVD, 5'd4, 1'b0);
        wait_r(2);
        check("rsvd_no_req", req_log.size(), 0);
        check("rsvd_beat0", {r_log[0].data, r_log[0].resp, r_log[0].last}, {64'd0, 2'b10, 1'b0});
        check("rsvd_beat1", {r_log[1].data, r_log[1].resp, r_log[1].last}, {64'd0, 2'b10, 1'b1});
        check("rsvd_id", r_log[1].id, 5'd4);

        // Reset during R_WAIT, then a clean read
        clear_logs();
        for (int i = 0; i < 4; i++) rd_q.push_back({1'b0, 64'hDEAD});
        send_ar(32'h6000, 8'd3, 3'd3, INCR, 5'd9, 1'b0);
        for (int i = 0; i < 50 && !o_req_valid; i++) @(negedge i_clk);
        @(posedge i_clk); #2;
        i_nrst = 1'b0;
        @(negedge i_clk);
        check("midrst_valids", {o_ar_ready, o_aw_ready, o_w_ready, o_b_valid, o_r_valid, o_req_valid}, 0);
        rd_q.delete();
        @(negedge i_clk); i_nrst = 1'b1;
        repeat (3) @(negedge i_clk);
        check("midrst_no_beat", r_log.size(), 0);
        @(posedge i_clk); #1;
        clear_logs();
        rd_q.push_back({1'b0, 64'h77});
        send_ar(32'h7000, 8'd0, 3'd3, INCR, 5'd1, 1'b0);
        wait_r(1);
        check("post_rst_addr", req_log[0].addr, 32'h7000);
        check("post_rst_beat", {r_log[0].data, r_log[0].resp, r_log[0].last}, {64'h77, 2'b00, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_sram_bridge.md
Name: axi4_sram_bridge

Overview:
- AXI4 slave endpoint that converts AXI4 read and write bursts into single-beat requests on a simple memory port, one beat at a time.
- Sits directly downstream of the system-bus interconnect, on the slave side.
- Feeds SRAM, ROM and register-file style slaves that have a request/ready, response-valid interface.
- Uses the system-bus widths (32-bit address, 64-bit data, 5-bit ID, 1-bit user) and the AXI RESP/BURST encodings.

Parameters:
- ADDR_BITS, 32, address width
- DATA_BYTES, 8, data bus bytes; data width = 8*DATA_BYTES
- ID_BITS, 5, AXI ID width
- USER_BITS, 1, AXI user width

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_aw_valid/o_aw_ready  in/out  1  write-address handshake
- i_aw_addr  in  ADDR_BITS  write start address
- i_aw_len  in  8  write beats minus 1
- i_aw_size  in  3  log2 bytes per beat
- i_aw_burst  in  2  write burst type
- i_aw_id  in  ID_BITS  write ID
- i_aw_user  in  USER_BITS  write user bits
- i_w_valid/o_w_ready  in/out  1  write-data handshake
- i_w_data  in  64  write data
- i_w_strb  in  8  byte strobes
- i_w_last  in  1  last write beat
- o_b_valid/i_b_ready  out/in  1  write-response handshake
- o_b_resp  out  2  write response
- o_b_id  out  ID_BITS  write-response ID
- o_b_user  out  USER_BITS  write-response user
- i_ar_*  in  (same fields as aw)  read-address channel; o_ar_ready out 1
- o_r_valid/i_r_ready  out/in  1  read-data handshake
- o_r_data  out  64  read data
- o_r_resp  out  2  read response
- o_r_last  out  1  last read beat
- o_r_id  out  ID_BITS  read-data ID
- o_r_user  out  USER_BITS  read-data user
- o_req_valid  out  1  memory request valid
- o_req_write  out  1  1=write, 0=read
- o_req_addr  out  ADDR_BITS  memory byte address
- o_req_wdata  out  64  memory write data
- o_req_wstrb  out  8  memory byte strobes
- i_req_ready  in  1  memory accepts request
- i_resp_valid  in  1  memory response valid, >=1 cycle after accept
- i_resp_rdata  in  64  memory read data
- i_resp_err  in  1  memory access error

Behaviour:
- Reset (async, i_nrst=0): all *_ready, *_valid outputs 0; data/addr/resp outputs 0; state=IDLE; priority=READ.
- States: IDLE, R_REQ, R_WAIT, R_DATA, W_DATA, W_REQ, W_WAIT, B_RESP.
- IDLE: o_ar_ready=1 and o_aw_ready=1 only if the corresponding valid is selected.
  - One valid only: that channel is accepted.
  - Both valid same cycle: channel per priority flag; flag toggles after each accepted burst (read/write alternation, no starvation).
  - Accept latches addr, len, size, burst, id, user; beat counter = len.
  - Read → R_REQ; write → W_DATA.
- Reserved burst type (2'b11), or size > log2(DATA_BYTES): no memory access.
  - Read: returns len+1 beats with SLVERR, data 0.
  - Write: consumes all W beats, B=SLVERR.
- R_REQ: o_req_valid=1, o_req_write=0; on i_req_ready → R_WAIT.
- R_WAIT: on i_resp_valid, register rdata and resp (OKAY=0, or SLVERR=2 if i_resp_err) → R_DATA.
- R_DATA: o_r_valid=1, o_r_last = (counter==0).
  - On i_r_ready: if last → IDLE, else advance address, decrement counter → R_REQ.
  - o_r_* held stable while stalled.
- W_DATA: o_w_ready=1; on i_w_valid, latch data/strb → W_REQ.
- W_REQ: o_req_valid=1, o_req_write=1; on i_req_ready → W_WAIT.
- W_WAIT: on i_resp_valid, sticky-OR i_resp_err into error flag.
  - If counter==0 → B_RESP, else advance address, decrement → W_DATA.
  - i_w_last mismatch with counter is ignored; counter governs.
- B_RESP: o_b_valid=1, resp = SLVERR if error flag else OKAY; flag cleared on i_b_ready → IDLE.
- Address advance (step = 2^size):
  - FIXED: unchanged.
  - INCR: addr+step, wraps modulo 2^ADDR_BITS.
  - WRAP: window = (len+1)*step, aligned to window size; addr = base | ((addr+step) & (window-1)).
- o_req_valid, once asserted, holds with stable fields until i_req_ready.
- Throughput: one memory request outstanding at most. Read beat period ≥ 3 cycles for a 1-cycle-latency memory.
- Reset mid-burst: aborts immediately. An in-flight memory response after reset is ignored (state=IDLE).

Test Plan:
- AR addr=0x1000, len=3, size=3, INCR; memory returns 0x11..0x44 → req addrs 0x1000/08/10/18; 4 R beats OKAY, last on 4th; id echoed.
- AR addr=0x1018, len=3, size=3, WRAP → req addrs 0x1018, 0x1000, 0x1008, 0x1010.
- AW addr=0x2000, len=1, strb=0xF0 then 0x0F, second memory resp err=1 → 2 write reqs with those strobes; B resp=SLVERR(2), o_b_id matches.
- AR and AW valid same cycle, twice in a row → read first, write second, then write first on the next collision.
- AR burst=2'b11, len=1 → no o_req_valid; 2 R beats, resp=2, data 0, last on 2nd.
- Assert i_nrst=0 during R_WAIT of a 4-beat read → all valids 0 next edge; new AR after reset completes normally.
